// File: rtl/tensor_hopper_uop_tracker_pkg.sv
// Shared types and widths for the tensor uop tracker.
// NUM_WARPS may be overridden with the `NUM_WARPS macro.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

package tensor_hopper_uop_tracker_pkg;

    localparam int NUM_THREADS = 4;
    localparam int XLEN        = 32;
    localparam int UUID_W      = 16;
    localparam int WID_W       = 3;
    localparam int PC_W        = 32;
    localparam int RD_W        = 5;
    localparam int PID_W       = 1;
    localparam int DATA_W      = NUM_THREADS * XLEN;

    localparam int DEF_NUM_WARPS = `NUM_WARPS;

    typedef struct packed {
        logic [UUID_W-1:0]      uuid;
        logic [WID_W-1:0]       wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_W-1:0]        PC;
        logic                   wb;
        logic [RD_W-1:0]        rd;
    } tensor_uop_meta_t;

    localparam int TENSOR_UOP_META_W = $bits(tensor_uop_meta_t);

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/tensor_hopper_uop_tracker_if.sv
// Issue and commit port bundles used by the tensor uop tracker.
interface VX_execute_if;
    import tensor_hopper_uop_tracker_pkg::*;

    logic                   valid;
    logic                   ready;
    logic [UUID_W-1:0]      uuid;
    logic [WID_W-1:0]       wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_W-1:0]        PC;
    logic                   wb;
    logic [RD_W-1:0]        rd;

    modport master (output valid, uuid, wid, tmask, PC, wb, rd, input ready);
    modport slave  (input valid, uuid, wid, tmask, PC, wb, rd, output ready);
endinterface

interface VX_commit_if;
    import tensor_hopper_uop_tracker_pkg::*;

    logic                   valid;
    logic                   ready;
    logic [UUID_W-1:0]      uuid;
    logic [WID_W-1:0]       wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_W-1:0]        PC;
    logic                   wb;
    logic [RD_W-1:0]        rd;
    logic [DATA_W-1:0]      data;
    logic [PID_W-1:0]       pid;
    logic                   sop;
    logic                   eop;

    modport master (output valid, uuid, wid, tmask, PC, wb, rd, data, pid, sop, eop, input ready);
    modport slave  (input valid, uuid, wid, tmask, PC, wb, rd, data, pid, sop, eop, output ready);
endinterface

// File: rtl/tensor_hopper_uop_tracker_warp_slot.sv
// Per-warp in-order uop queue with head latency countdown.
// Countdown is present only when TENSOR_HOPPER_LATENCY_MODEL_EN is defined.
module tensor_hopper_warp_slot
    import tensor_hopper_uop_tracker_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  tensor_uop_meta_t push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             eligible_o,
    output tensor_uop_meta_t head_o
);

    localparam int PTR_W  = clog2_min1(DEPTH);
    localparam int SIZE_W = $clog2(DEPTH + 1);
    localparam int CNT_W  = clog2_min1(LATENCY + 1);

    logic [TENSOR_UOP_META_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic              empty;
    logic [CNT_W-1:0]  cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty    = (size_q == '0);
        full_o   = (size_q == SIZE_W'(DEPTH));
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        size_d   = size_q;
        case ({push_i, pop_i})
            2'b10:   size_d = size_q + 1'b1;
            2'b01:   size_d = size_q - 1'b1;
            default: size_d = size_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            size_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            size_q   <= size_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

`ifdef TENSOR_HOPPER_LATENCY_MODEL_EN
    logic [CNT_W-1:0] cnt_d;
    logic             load_head;

    // A new head appears on push into empty, or on a pop that leaves something behind.
    always_comb begin
        load_head = (push_i && empty) || (pop_i && ((size_q > SIZE_W'(1)) || push_i));
        cnt_d     = cnt_q;
        if (load_head) begin
            cnt_d = CNT_W'(LATENCY);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign cnt_q = '0;
`endif

    assign eligible_o = !empty && (cnt_q == '0);
    assign head_o     = tensor_uop_meta_t'(mem_q[rd_ptr_q]);

`ifndef SYNTHESIS
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) pop_i |-> !empty);
`endif

endmodule

// File: rtl/tensor_hopper_uop_tracker.sv
// Per-warp tensor uop tracking with round-robin commit arbitration and grant lock.
// Latency modelling is enabled by defining TENSOR_HOPPER_LATENCY_MODEL_EN.
module tensor_hopper_uop_tracker
    import tensor_hopper_uop_tracker_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int DEPTH     = 2,
    parameter int LATENCY   = 8
) (
    input  logic         clk,
    input  logic         reset,
    VX_execute_if.slave  execute_if,
    VX_commit_if.master  commit_if,
    output logic [31:0]  perf_stall_cycles
);

    localparam int IDX_W = clog2_min1(NUM_WARPS);

    logic [NUM_WARPS-1:0] push_vec, pop_vec, full_vec, elig_vec;
    tensor_uop_meta_t     head_arr [NUM_WARPS];
    tensor_uop_meta_t     in_meta, grant_meta;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, rr_idx, grant_idx;
    logic                 lock_q, lock_d, rr_found, sel_full, exe_ready, exe_fire;
    logic                 cmt_valid, cmt_fire;
    logic [31:0]          perf_q, perf_d;
    int                   j;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_slot
        tensor_hopper_warp_slot #(
            .DEPTH   (DEPTH),
            .LATENCY (LATENCY)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .push_i      (push_vec[w]),
            .push_data_i (in_meta),
            .pop_i       (pop_vec[w]),
            .full_o      (full_vec[w]),
            .eligible_o  (elig_vec[w]),
            .head_o      (head_arr[w])
        );
    end

    // An out-of-range wid is treated as full so it can never be accepted.
    always_comb begin
        in_meta.uuid  = execute_if.uuid;
        in_meta.wid   = execute_if.wid;
        in_meta.tmask = execute_if.tmask;
        in_meta.PC    = execute_if.PC;
        in_meta.wb    = execute_if.wb;
        in_meta.rd    = execute_if.rd;
        sel_full      = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (execute_if.wid == WID_W'(w)) begin
                sel_full = full_vec[w];
            end
        end
        exe_ready = !sel_full;
        exe_fire  = execute_if.valid && exe_ready;
        push_vec  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            push_vec[w] = exe_fire && (execute_if.wid == WID_W'(w));
        end
    end

    always_comb begin
        rr_idx   = rr_ptr_q;
        rr_found = 1'b0;
        j        = 0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_WARPS) begin
                j = j - NUM_WARPS;
            end
            if (!rr_found && elig_vec[IDX_W'(j)]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(j);
            end
        end

        grant_idx  = lock_q ? lock_idx_q : rr_idx;
        cmt_valid  = lock_q || rr_found;
        cmt_fire   = cmt_valid && commit_if.ready;
        grant_meta = '0;
        pop_vec    = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (grant_idx == IDX_W'(w)) begin
                grant_meta = head_arr[w];
                pop_vec[w] = cmt_fire;
            end
        end

        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (cmt_fire) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_WARPS - 1)) ? '0 : grant_idx + 1'b1;
            lock_d   = 1'b0;
        end else if (cmt_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
        end

        perf_d = perf_q;
        if (execute_if.valid && !exe_ready && (perf_q != '1)) begin
            perf_d = perf_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            perf_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            perf_q     <= perf_d;
        end
    end

    assign execute_if.ready  = exe_ready;
    assign commit_if.valid   = cmt_valid;
    assign commit_if.uuid    = grant_meta.uuid;
    assign commit_if.wid     = grant_meta.wid;
    assign commit_if.tmask   = grant_meta.tmask;
    assign commit_if.PC      = grant_meta.PC;
    assign commit_if.wb      = grant_meta.wb;
    assign commit_if.rd      = grant_meta.rd;
    assign commit_if.data    = '0;
    assign commit_if.pid     = '0;
    assign commit_if.sop     = 1'b1;
    assign commit_if.eop     = 1'b1;
    assign perf_stall_cycles = perf_q;

`ifndef SYNTHESIS
    a_wid_range: assert property (@(posedge clk) disable iff (reset)
        execute_if.valid |-> (int'(execute_if.wid) < NUM_WARPS));
    a_commit_stable: assert property (@(posedge clk) disable iff (reset)
        (cmt_valid && !commit_if.ready) |=> (cmt_valid && $stable(grant_meta)));
`endif

endmodule

// File: tb/tb_tensor_hopper_uop_tracker.sv
// Scoreboard bench for tensor_hopper_uop_tracker (follows TENSOR_HOPPER_LATENCY_MODEL_EN).
module tb_tensor_hopper_uop_tracker;
    import tensor_hopper_uop_tracker_pkg::*;

    localparam int NW    = 4;
    localparam int DEPTH = 2;
    localparam int LAT   = 3;
`ifdef TENSOR_HOPPER_LATENCY_MODEL_EN
    localparam int L_EFF = LAT;
`else
    localparam int L_EFF = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] perf;

    VX_execute_if eif ();
    VX_commit_if  cif ();

    tensor_hopper_uop_tracker #(
        .NUM_WARPS (NW),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .execute_if        (eif),
        .commit_if         (cif),
        .perf_stall_cycles (perf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [UUID_W-1:0]      uuid;
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_W-1:0]        pc;
        logic                   wb;
        logic [RD_W-1:0]        rd;
    } ent_t;

    ent_t mq [NW][$];
    int   head_elig [NW];
    int   rr_m, lock_w, cyc, perf_m, errors, checks, e0_cycle;
    bit   lock_m, done, e0_seen;
    int   c0_cycles [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: per-warp queues with absolute eligibility cycle of each head.
    always @(negedge clk) begin : mon
        int   g, w;
        bit   ev, er;
        ent_t e;
        if (!done) begin
            ev = lock_m;
            g  = lock_w;
            if (!lock_m) begin
                for (int i = 0; i < NW; i++) begin
                    w = (rr_m + i) % NW;
                    if (!ev && mq[w].size() > 0 && cyc >= head_elig[w]) begin
                        ev = 1'b1;
                        g  = w;
                    end
                end
            end
            w  = int'(eif.wid);
            er = (mq[w].size() < DEPTH);
            chk("exec_ready", eif.ready, er);
            chk("commit_valid", cif.valid, ev);
            chk("perf_stall", perf, perf_m);
            if (ev && cif.valid) begin
                e = mq[g][0];
                chk("commit_wid", cif.wid, g);
                chk("commit_uuid", cif.uuid, e.uuid);
                chk("commit_pc", cif.PC, e.pc);
                chk("commit_rd", cif.rd, e.rd);
                chk("commit_tmask", cif.tmask, e.tmask);
                chk("commit_wb", cif.wb, e.wb);
                chk("commit_data_zero", (cif.data == '0), 1'b1);
                chk("commit_pid", cif.pid, 0);
                chk("commit_sop_eop", {cif.sop, cif.eop}, 2'b11);
            end
            if (reset) begin
                for (int k = 0; k < NW; k++) mq[k].delete();
                rr_m   = 0;
                lock_m = 1'b0;
                perf_m = 0;
            end else begin
                if (eif.valid && !er) perf_m++;
                if (ev && cif.ready) begin
                    if (g == 0) c0_cycles.push_back(cyc);
                    void'(mq[g].pop_front());
                    if (mq[g].size() > 0) head_elig[g] = cyc + 1 + L_EFF;
                    rr_m   = (g + 1) % NW;
                    lock_m = 1'b0;
                end else if (ev) begin
                    lock_m = 1'b1;
                    lock_w = g;
                end
                if (eif.valid && er) begin
                    e.uuid  = eif.uuid;
                    e.tmask = eif.tmask;
                    e.pc    = eif.PC;
                    e.wb    = eif.wb;
                    e.rd    = eif.rd;
                    if (mq[w].size() == 0) head_elig[w] = cyc + 1 + L_EFF;
                    mq[w].push_back(e);
                    if (w == 0 && !e0_seen) begin
                        e0_seen  = 1'b1;
                        e0_cycle = cyc;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic randomize_fields();
        eif.uuid  = UUID_W'($urandom);
        eif.tmask = NUM_THREADS'($urandom);
        eif.PC    = PC_W'($urandom);
        eif.wb    = 1'($urandom);
        eif.rd    = RD_W'($urandom);
    endtask

    task automatic send(input int w);
        bit acc;
        acc = 1'b0;
        eif.valid = 1'b1;
        eif.wid   = WID_W'(w);
        randomize_fields();
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            acc = eif.ready;
            @(posedge clk);
            #1;
        end
        eif.valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: warp %0d got ready=0 expected accept within 60 cycles", w);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        eif.valid = 1'b0;
        eif.wid   = '0;
        randomize_fields();
        cif.ready = 1'b0;
        errors = 0;
        checks = 0;
        cyc    = 0;
        step(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_exec_ready", eif.ready, 1'b1);
        chk("rst_commit_valid", cif.valid, 1'b0);
        chk("rst_perf", perf, 0);
        step(1);

        // Single uop, commit always ready.
        cif.ready = 1'b1;
        send(2);
        step(L_EFF + 4);

        // Per-warp backpressure: warp 1 full, warp 3 still accepted.
        cif.ready = 1'b0;
        send(1);
        send(1);
        eif.valid = 1'b1;
        eif.wid   = WID_W'(1);
        @(negedge clk);
        chk("bp_ready_w1", eif.ready, 1'b0);
        step(3);
        eif.valid = 1'b0;
        send(3);
        cif.ready = 1'b1;
        step(3 * (L_EFF + 2) + 6);

        // Round-robin from rr_ptr=0 over warps 0, 1, 3.
        pulse_reset();
        cif.ready = 1'b0;
        send(0);
        send(1);
        send(3);
        step(L_EFF + 3);
        cif.ready = 1'b1;
        step(6);

        // Grant lock on warp 2 while warp 0 becomes eligible.
        cif.ready = 1'b0;
        send(2);
        step(L_EFF + 2);
        send(0);
        step(L_EFF + 5);
        cif.ready = 1'b1;
        step(L_EFF + 6);

        // In-order spacing within warp 0.
        c0_cycles.delete();
        e0_seen = 1'b0;
        send(0);
        send(0);
        send(0);
        step(4 * (L_EFF + 1) + 6);
        chk("spacing_count", c0_cycles.size(), 3);
        if (c0_cycles.size() == 3) begin
            chk("spacing_first", c0_cycles[0], e0_cycle + 1 + L_EFF);
            chk("spacing_second", c0_cycles[1] - c0_cycles[0], L_EFF + 1);
            chk("spacing_third", c0_cycles[2] - c0_cycles[1], L_EFF + 1);
        end

        // Reset with entries in flight discards them.
        cif.ready = 1'b0;
        send(0);
        send(1);
        send(2);
        pulse_reset();
        cif.ready = 1'b1;
        @(negedge clk);
        chk("midrst_exec_ready", eif.ready, 1'b1);
        chk("midrst_commit_valid", cif.valid, 1'b0);
        chk("midrst_perf", perf, 0);
        step(L_EFF + 6);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            eif.valid = 1'($urandom_range(0, 1));
            eif.wid   = WID_W'($urandom_range(0, NW - 1));
            randomize_fields();
            cif.ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 599) == 0);
            step(1);
        end
        reset     = 1'b0;
        eif.valid = 1'b0;
        cif.ready = 1'b1;
        step(NW * DEPTH * (L_EFF + 2) + 10);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
